// File: rtl/data_mem_resp.sv
// Multi-cycle data-memory responder: one request at a time, fixed latency,
// RISC-V byte/half/word stores and sign/zero-extended loads, error flagging.
module data_mem_resp #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state, next_state;
   logic [3:0]          cnt;
   logic                lat_we;
   logic [ADDR_W+1:0]   lat_addr;
   logic [1:0]          lat_size;
   logic                lat_unsigned;
   logic [31:0]         lat_wdata;
   logic [31:0]         mem [DEPTH];

   logic                accept, finish, commit, err_c;
   logic [ADDR_W-1:0]   word_idx;
   logic [31:0]         rd_word, load_val, lane_data;
   logic [3:0]          lane_we;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;

   // Address bits above the array are intentionally dropped: the space wraps.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;
   assign finish     = (state == WAIT) && (cnt == 4'd0);
   assign word_idx   = lat_addr[ADDR_W+1:2];
   assign commit     = finish && lat_we && !err_c;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: every combinational output gets a default first, so no path
   // through the case leaves a signal unassigned and infers a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req_valid)     next_state = WAIT;
         WAIT:    if (cnt == 4'd0)   next_state = RESP;
         RESP:    if (resp_ready)    next_state = IDLE;
         default:                    next_state = IDLE;
      endcase
   end

   always_comb begin
      err_c = (lat_size == 2'b11)
            | ((lat_size == 2'b01) & lat_addr[0])
            | ((lat_size == 2'b10) & (lat_addr[1:0] != 2'b00));

      rd_word = mem[word_idx];
      ld_byte = 8'(rd_word >> {lat_addr[1:0], 3'b000});
      ld_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

      case (lat_size)
         2'b00:   load_val = lat_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   load_val = lat_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: load_val = rd_word;
      endcase

      // Store data is replicated across lanes; lane_we picks the live ones.
      case (lat_size)
         2'b00: begin
            lane_we   = 4'b0001 << lat_addr[1:0];
            lane_data = {4{lat_wdata[7:0]}};
         end
         2'b01: begin
            lane_we   = lat_addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{lat_wdata[15:0]}};
         end
         2'b10: begin
            lane_we   = 4'b1111;
            lane_data = lat_wdata;
         end
         default: begin
            lane_we   = 4'b0000;
            lane_data = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= 4'd0;
         lat_we       <= 1'b0;
         lat_addr     <= '0;
         lat_size     <= 2'b00;
         lat_unsigned <= 1'b0;
         lat_wdata    <= 32'd0;
         resp_rdata   <= 32'd0;
         resp_err     <= 1'b0;
      end else begin
         if (accept) begin
            cnt          <= 4'(LATENCY - 1);
            lat_we       <= req_we;
            lat_addr     <= req_addr[ADDR_W+1:0];
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
         end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end

         if (finish) begin
            resp_err   <= err_c;
            resp_rdata <= (err_c || lat_we) ? 32'd0 : load_val;
         end else if (resp_valid && resp_ready) begin
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
         end
      end
   end

   // NOTE: the storage array has no reset; clearing it would force a
   // flop-based implementation instead of a RAM macro.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed scenarios plus randomized
// traffic scored against a byte-addressed reference memory.
module tb_data_mem_resp;

   localparam int ADDR_W  = 8;
   localparam int LATENCY = 2;
   localparam int NBYTES  = 1 << (ADDR_W + 2);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] ref_mem [NBYTES];

   always #5 clk = ~clk;

   data_mem_resp #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   // Reference: a flat byte array, little-endian, address wraps at NBYTES.
   function automatic void model_op(input bit we, input logic [31:0] addr,
                                    input logic [1:0] size, input bit uns,
                                    input logic [31:0] wdata,
                                    output logic [31:0] rdata, output logic err);
      int base, n;
      logic [31:0] v;
      base  = int'(addr % NBYTES);
      n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      rdata = 32'd0;
      err   = (size == 2'd3) || (base % n != 0);
      if (err) return;
      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
         if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         rdata = v;
      end
   endfunction

   // Driver only: performs one transaction and reports what it saw.
   task automatic txn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                      input bit uns, input logic [31:0] wdata, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
      rdata = resp_rdata;
      err   = resp_err;
      repeat (hold) @(negedge clk);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_total++;
      if ({req_ready, resp_valid, resp_err} !== 3'b100 || resp_rdata !== 32'd0) begin
         $display("FAIL reset_outputs: got ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                  req_ready, resp_valid, resp_err, resp_rdata);
      end else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         $display("FAIL reset_release: got ready=%b valid=%b, want 1 0", req_ready, resp_valid);
      end else n_pass++;
   endtask

   task automatic test_word_roundtrip();
      logic [31:0] rd, mrd; logic er, mer; int lat;
      txn(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, rd, er, lat);
      model_op(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, mrd, mer);
      n_total++;
      if (lat !== LATENCY || rd !== 32'd0 || er !== 1'b0) begin
         $display("FAIL sw_roundtrip: got lat=%0d rdata=%h err=%b, want lat=%0d rdata=00000000 err=0",
                  lat, rd, er, LATENCY);
      end else n_pass++;
      txn(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 0, rd, er, lat);
      n_total++;
      if (lat !== LATENCY || rd !== 32'hDEADBEEF || er !== 1'b0) begin
         $display("FAIL lw_roundtrip: got lat=%0d rdata=%h err=%b, want lat=%0d rdata=deadbeef err=0",
                  lat, rd, er, LATENCY);
      end else n_pass++;
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd, mrd; logic er, mer; int lat;
      txn(1'b1, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er, lat);
      model_op(1'b1, 32'h20, 2'b10, 1'b0, 32'h0, mrd, mer);
      txn(1'b1, 32'h22, 2'b00, 1'b0, 32'h000000A5, 0, rd, er, lat);
      model_op(1'b1, 32'h22, 2'b00, 1'b0, 32'h000000A5, mrd, mer);
      txn(1'b1, 32'h20, 2'b01, 1'b0, 32'h00001234, 0, rd, er, lat);
      model_op(1'b1, 32'h20, 2'b01, 1'b0, 32'h00001234, mrd, mer);
      txn(1'b0, 32'h20, 2'b10, 1'b0, 32'd0, 0, rd, er, lat);
      n_total++;
      if (rd !== 32'h00A51234 || er !== 1'b0) begin
         $display("FAIL byte_lanes: got rdata=%h err=%b, want 00a51234 0", rd, er);
      end else n_pass++;
   endtask

   task automatic test_extension();
      logic [31:0] rd, mrd; logic er, mer; int lat;
      logic [31:0] a_tab [5] = '{32'h25, 32'h25, 32'h26, 32'h26, 32'h24};
      logic [1:0]  s_tab [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
      bit          u_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] e_tab [5] = '{32'h0000007F, 32'h0000007F, 32'hFFFF80FF,
                                 32'h000080FF, 32'h00000001};
      txn(1'b1, 32'h24, 2'b10, 1'b0, 32'h80FF7F01, 0, rd, er, lat);
      model_op(1'b1, 32'h24, 2'b10, 1'b0, 32'h80FF7F01, mrd, mer);
      for (int i = 0; i < 5; i++) begin
         txn(1'b0, a_tab[i], s_tab[i], u_tab[i], 32'd0, 0, rd, er, lat);
         n_total++;
         if (rd !== e_tab[i] || er !== 1'b0) begin
            $display("FAIL extension[%0d]: got rdata=%h err=%b, want %h 0", i, rd, er, e_tab[i]);
         end else n_pass++;
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd, mrd; logic er, mer; int lat;
      bit          w_tab [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] a_tab [3] = '{32'h31, 32'h32, 32'h30};
      logic [1:0]  s_tab [3] = '{2'b01, 2'b10, 2'b11};
      txn(1'b1, 32'h30, 2'b10, 1'b0, 32'hCAFEF00D, 0, rd, er, lat);
      model_op(1'b1, 32'h30, 2'b10, 1'b0, 32'hCAFEF00D, mrd, mer);
      for (int i = 0; i < 3; i++) begin
         txn(w_tab[i], a_tab[i], s_tab[i], 1'b0, 32'h5A5A5A5A, 0, rd, er, lat);
         n_total++;
         if (rd !== 32'd0 || er !== 1'b1) begin
            $display("FAIL error[%0d]: got rdata=%h err=%b, want 00000000 1", i, rd, er);
         end else n_pass++;
      end
      txn(1'b0, 32'h30, 2'b10, 1'b0, 32'd0, 0, rd, er, lat);
      n_total++;
      if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
         $display("FAIL error_nowrite: got rdata=%h err=%b, want cafef00d 0", rd, er);
      end else n_pass++;
   endtask

   task automatic test_backpressure();
      int n;
      bit bad;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
      @(negedge clk);
      // A store is offered while busy; it must be ignored.
      req_we = 1'b1; req_wdata = 32'h0BADF00D;
      n = 0;
      while (!resp_valid && n < 40) begin @(negedge clk); n++; end
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0 || req_ready !== 1'b0)
            bad = 1'b1;
         if (i < 4) @(negedge clk);
      end
      n_total++;
      if (bad) begin
         $display("FAIL backpressure_hold: got valid=%b rdata=%h err=%b ready=%b, want 1 deadbeef 0 0",
                  resp_valid, resp_rdata, resp_err, req_ready);
      end else n_pass++;
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      n_total++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
         $display("FAIL backpressure_release: got ready=%b valid=%b rdata=%h, want 1 0 00000000",
                  req_ready, resp_valid, resp_rdata);
      end else n_pass++;
   endtask

   task automatic test_reset_midop();
      logic [31:0] rd, mrd; logic er, mer; int lat;
      txn(1'b1, 32'h40, 2'b10, 1'b0, 32'h11111111, 0, rd, er, lat);
      model_op(1'b1, 32'h40, 2'b10, 1'b0, 32'h11111111, mrd, mer);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10;
      req_wdata = 32'h22222222;
      @(negedge clk);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({req_ready, resp_valid, resp_err} !== 3'b100 || resp_rdata !== 32'd0) begin
         $display("FAIL reset_midop_outputs: got ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                  req_ready, resp_valid, resp_err, resp_rdata);
      end else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn(1'b0, 32'h40, 2'b10, 1'b0, 32'd0, 0, rd, er, lat);
      n_total++;
      if (rd !== 32'h11111111 || er !== 1'b0) begin
         $display("FAIL reset_midop_nowrite: got rdata=%h err=%b, want 11111111 0", rd, er);
      end else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, mrd, addr, wd; logic er, mer; int lat;
      logic [1:0] sz; bit we, uns;
      int errs;
      for (int w = 0; w < 16; w++) begin
         wd = $urandom;
         txn(1'b1, 32'h200 + 4*w, 2'b10, 1'b0, wd, 0, rd, er, lat);
         model_op(1'b1, 32'h200 + 4*w, 2'b10, 1'b0, wd, mrd, mer);
      end
      errs = 0;
      for (int i = 0; i < 80; i++) begin
         // Random upper bits exercise the address wrap.
         addr = (32'h200 + 32'($urandom_range(0, 63))) | ($urandom << (ADDR_W + 2));
         sz   = 2'($urandom_range(0, 3));
         we   = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         wd   = $urandom;
         txn(we, addr, sz, uns, wd, $urandom_range(0, 2), rd, er, lat);
         model_op(we, addr, sz, uns, wd, mrd, mer);
         n_total++;
         if (lat !== LATENCY || rd !== mrd || er !== mer) begin
            errs++;
            if (errs <= 5)
               $display("FAIL random[%0d] we=%b addr=%h size=%0d uns=%b: got lat=%0d rdata=%h err=%b, want lat=%0d rdata=%h err=%b",
                        i, we, addr, sz, uns, lat, rd, er, LATENCY, mrd, mer);
         end else n_pass++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_word_roundtrip();
      test_byte_lanes();
      test_extension();
      test_errors();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
